// File: rtl/syscall_unit.sv
// syscall_unit: responder for the decoder's syscall interface.
// It handles console I/O (print int, print char, read int) and exit for the
// single-cycle CPU. While a service is running, stall holds the PC.
// The console is reached through byte-wide valid/ready TX and RX streams.
// Optional build macro: SYSCALL_ECHO_EN. When it is defined, every byte taken
// in during INPUT_INT, the terminator included, is echoed back on TX.

`ifndef SYS_OP_LENGTH
`define SYS_OP_LENGTH 4
`endif

module syscall_unit #(
  parameter int DATA_W = 32,
  parameter int OP_W   = `SYS_OP_LENGTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              syscall,
  input  logic [OP_W-1:0]   sys_op,
  input  logic [DATA_W-1:0] arg,
  output logic              stall,
  output logic [DATA_W-1:0] wb_data,
  output logic              halt,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam logic [OP_W-1:0] SYSCALL_PRINT_INT  = OP_W'(1);
  localparam logic [OP_W-1:0] SYSCALL_INPUT_INT  = OP_W'(5);
  localparam logic [OP_W-1:0] SYSCALL_EXIT       = OP_W'(10);
  localparam logic [OP_W-1:0] SYSCALL_PRINT_CHAR = OP_W'(11);

  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P_SIGN,
    S_P_DIGIT,
    S_P_CHAR,
    S_R_WAIT,
`ifdef SYSCALL_ECHO_EN
    S_R_ECHO,
`endif
    S_DONE,
    S_HALTED
  } state_t;

  state_t state;

  logic [DATA_W-1:0] arg_q;
  logic [DATA_W-1:0] mag;
  logic [3:0]        pow_idx;
  logic [3:0]        digit;
  logic              lead;
  logic [DATA_W-1:0] acc;
  logic              neg;
  logic              got_digit;
`ifdef SYSCALL_ECHO_EN
  logic              term_pending;
`endif

  logic              rx_fire;
  logic              tx_fire;
  logic              rx_is_minus;
  logic              rx_is_digit;
  logic [DATA_W-1:0] pow_val;
  logic [DATA_W-1:0] acc_next;

  // Powers of ten, 10^0 .. 10^9. Every one of them fits in 32 bits.
  function automatic logic [DATA_W-1:0] pow10(input logic [3:0] idx);
    logic [DATA_W-1:0] p;
    case (idx)
      4'd0:    p = 32'd1;
      4'd1:    p = 32'd10;
      4'd2:    p = 32'd100;
      4'd3:    p = 32'd1000;
      4'd4:    p = 32'd10000;
      4'd5:    p = 32'd100000;
      4'd6:    p = 32'd1000000;
      4'd7:    p = 32'd10000000;
      4'd8:    p = 32'd100000000;
      4'd9:    p = 32'd1000000000;
      default: p = 32'd1;
    endcase
    return p;
  endfunction

  // Stall the PC while a service is running. Also stall on the issuing cycle,
  // so the CPU does not advance before the unit has latched the request.
  always_comb begin
    stall = 1'b0;
    if (state == S_IDLE)
      stall = syscall;
    else if (state != S_DONE && state != S_HALTED)
      stall = 1'b1;
  end

  // Handshake strobes, RX byte classification and the next decimal accumulation.
  always_comb begin
    rx_fire     = rx_valid & rx_ready;
    tx_fire     = tx_valid & tx_ready;
    rx_is_minus = (rx_data == CH_MINUS) & ~got_digit;
    rx_is_digit = (rx_data >= CH_ZERO) & (rx_data <= CH_NINE);
    pow_val     = pow10(pow_idx);
    acc_next    = (acc << 3) + (acc << 1) + {28'h0, rx_data[3:0]};
  end

  // Service sequencer. All console and writeback outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      arg_q     <= '0;
      mag       <= '0;
      pow_idx   <= '0;
      digit     <= '0;
      lead      <= 1'b0;
      acc       <= '0;
      neg       <= 1'b0;
      got_digit <= 1'b0;
      wb_data   <= '0;
      halt      <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      rx_ready  <= 1'b0;
`ifdef SYSCALL_ECHO_EN
      term_pending <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (syscall) begin
            arg_q <= arg;
            case (sys_op)
              SYSCALL_PRINT_INT:  state <= S_P_SIGN;
              SYSCALL_PRINT_CHAR: state <= S_P_CHAR;
              SYSCALL_INPUT_INT: begin
                acc       <= '0;
                neg       <= 1'b0;
                got_digit <= 1'b0;
                rx_ready  <= 1'b1;
                state     <= S_R_WAIT;
              end
              SYSCALL_EXIT: begin
                halt  <= 1'b1;
                state <= S_HALTED;
              end
              default: state <= S_DONE;
            endcase
          end
        end

        S_P_SIGN: begin
          pow_idx <= 4'd9;
          digit   <= '0;
          lead    <= 1'b1;
          if (arg_q[DATA_W-1]) begin
            if (!tx_valid) begin
              tx_valid <= 1'b1;
              tx_data  <= CH_MINUS;
            end else if (tx_ready) begin
              tx_valid <= 1'b0;
              mag      <= -arg_q;
              state    <= S_P_DIGIT;
            end
          end else begin
            mag   <= arg_q;
            state <= S_P_DIGIT;
          end
        end

        // Each digit is found by repeated subtraction, one subtraction per cycle.
        // The digit byte is held on TX until it is accepted. Only after that
        // does the power index step down.
        S_P_DIGIT: begin
          if (tx_valid) begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              digit    <= '0;
              if (pow_idx == 4'd0)
                state <= S_DONE;
              else
                pow_idx <= pow_idx - 4'd1;
            end
          end else if (mag >= pow_val) begin
            mag   <= mag - pow_val;
            digit <= digit + 4'd1;
          end else if (digit == 4'd0 && lead && pow_idx != 4'd0) begin
            pow_idx <= pow_idx - 4'd1;
          end else begin
            tx_valid <= 1'b1;
            tx_data  <= CH_ZERO + {4'h0, digit};
            lead     <= 1'b0;
          end
        end

        S_P_CHAR: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= arg_q[7:0];
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_DONE;
          end
        end

        S_R_WAIT: begin
          if (rx_fire) begin
            if (rx_is_minus) begin
              neg <= 1'b1;
            end else if (rx_is_digit) begin
              acc       <= acc_next;
              got_digit <= 1'b1;
            end else begin
              wb_data <= neg ? -acc : acc;
            end
`ifdef SYSCALL_ECHO_EN
            rx_ready     <= 1'b0;
            tx_valid     <= 1'b1;
            tx_data      <= rx_data;
            term_pending <= ~rx_is_minus & ~rx_is_digit;
            state        <= S_R_ECHO;
`else
            if (!rx_is_minus && !rx_is_digit) begin
              rx_ready <= 1'b0;
              state    <= S_DONE;
            end
`endif
          end
        end

`ifdef SYSCALL_ECHO_EN
        S_R_ECHO: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            if (term_pending) begin
              state <= S_DONE;
            end else begin
              rx_ready <= 1'b1;
              state    <= S_R_WAIT;
            end
          end
        end
`endif

        S_DONE: state <= S_IDLE;

        S_HALTED: halt <= 1'b1;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
